writeback_arbiter: RTL
======================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3, range 1..3: consecutive cycles source A may lose arbitration before it is forced to win.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high, sampled on the rising edge of clk.
REQ-004 a_valid  input  1  ALU writeback request valid.
REQ-005 a_addr  input  5  ALU destination register index.
REQ-006 a_data  input  32  ALU result.
REQ-007 a_ready  output  1  ALU queue can accept an entry this cycle.
REQ-008 b_valid  input  1  load-unit writeback request valid.
REQ-009 b_addr  input  5  load destination register index.
REQ-010 b_data  input  32  load data.
REQ-011 b_ready  output  1  load queue can accept an entry this cycle.
REQ-012 reg_w_out  output  1  register-file write enable, one-cycle pulse per write.
REQ-013 reg_addr_w_out  output  5  register-file write index.
REQ-014 reg_data_w_out  output  32  register-file write data.
REQ-015 idle  output  1  both queues empty and no write pending on the outputs.

Function
REQ-016 Each source SHALL own a private 2-entry FIFO of {addr, data}; per-source write order is preserved.
REQ-017 x_ready SHALL be 1 iff that FIFO holds fewer than 2 entries, from registered count only (no same-cycle pop look-ahead).
REQ-018 An entry SHALL be pushed at a rising edge where x_valid=1 and x_ready=1; x_valid with x_ready=0 SHALL be ignored, and the source holds the request.
REQ-019 Each cycle the arbiter SHALL pop at most one head entry, chosen from registered FIFO state: B if B non-empty, else A if A non-empty.
REQ-020 Override: if A non-empty and skip_cnt equals STARVE_LIMIT, A SHALL be popped instead of B.
REQ-021 skip_cnt (2 bits) SHALL increment when A is non-empty and B is popped, clear when A is popped or A is empty, and never exceed STARVE_LIMIT.
REQ-022 Outputs SHALL be registered: at the edge ending a cycle with a pop of addr!=0, reg_w_out<=1 and addr/data<=popped entry; otherwise reg_w_out<=0.
REQ-023 A popped entry with addr==0 SHALL consume its slot but leave reg_w_out=0 for that cycle.
REQ-024 reg_addr_w_out and reg_data_w_out SHALL hold their last values while reg_w_out=0.
REQ-025 Latency: request sampled at edge E0 into an empty queue with no competing entries SHALL produce reg_w_out=1 in the cycle following edge E0+1 (2 edges).
REQ-026 Push and pop on the same FIFO in the same cycle SHALL both take effect (count unchanged).
REQ-027 Throughput SHALL be one write per cycle while either queue is non-empty.
REQ-028 idle SHALL be 1 iff both FIFO counts are 0 and reg_w_out=0.

Reset
REQ-029 On reset: both FIFO counts and pointers 0, skip_cnt 0, reg_w_out 0, reg_addr_w_out 0, reg_data_w_out 0; hence a_ready=1, b_ready=1, idle=1 after the edge.
REQ-030 Reset SHALL override any same-edge push or pop; queued entries are discarded and never written.

Verification
REQ-031 Single A write {addr 5, data 0x12345678} into empty block -> one cycle reg_w_out=1, addr 5, data 0x12345678, 2 edges after acceptance; idle returns to 1.
REQ-032 A and B valid at the same edge (A: r3=0xA, B: r4=0xB) -> r4 written first, r3 the next cycle.
REQ-033 A holds 1 entry, B fed back-to-back for 6 cycles, STARVE_LIMIT=3 -> three B writes, then A write, then B resumes; skip_cnt never exceeds 3.
REQ-034 Push 3 entries on A with no pops possible (B saturating, skip not yet limited) -> a_ready=0 after 2nd push, 3rd held until a slot frees, no entry lost or reordered.
REQ-035 B write to addr 0 followed by B write to addr 7 -> one idle write slot (reg_w_out=0), then r7 written; register 0 never written.
REQ-036 Reset asserted with both queues full -> next cycle a_ready=b_ready=idle=1, reg_w_out=0, no queued write ever appears.

Source files
------------

// File: rtl/writeback_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : writeback_arbiter
// Description : Two-source register-file writeback arbiter. Each source (ALU
//               "A", load unit "B") owns a private 2-entry FIFO. One head
//               entry is popped per cycle, B preferred, with a starvation
//               override that forces an A pop after STARVE_LIMIT consecutive
//               losses. Register-file write port is fully registered.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  // ALU writeback source
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  // Load-unit writeback source
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  // Register-file write port
  output logic        reg_w_out,
  output logic [4:0]  reg_addr_w_out,
  output logic [31:0] reg_data_w_out,
  output logic        idle
);

  localparam int         c_entry_w = 37;
  localparam logic [1:0] c_limit   = STARVE_LIMIT[1:0];

  // FIFO A storage and bookkeeping
  logic [c_entry_w-1:0] r_a_mem [2];
  logic                 r_a_wp;
  logic                 r_a_rp;
  logic [1:0]           r_a_cnt;

  // FIFO B storage and bookkeeping
  logic [c_entry_w-1:0] r_b_mem [2];
  logic                 r_b_wp;
  logic                 r_b_rp;
  logic [1:0]           r_b_cnt;

  logic [1:0]           r_skip_cnt;

  logic                 w_a_push;
  logic                 w_b_push;
  logic                 w_a_nempty;
  logic                 w_b_nempty;
  logic                 w_pop_a;
  logic                 w_pop_b;
  logic [c_entry_w-1:0] w_pop_entry;
  logic                 w_do_write;

  // Readiness comes from registered counts only, so a slot freed by this
  // cycle's pop is not offered until the next cycle.
  assign a_ready    = (r_a_cnt < 2'd2);
  assign b_ready    = (r_b_cnt < 2'd2);
  assign w_a_push   = a_valid & a_ready;
  assign w_b_push   = b_valid & b_ready;
  assign w_a_nempty = (r_a_cnt != 2'd0);
  assign w_b_nempty = (r_b_cnt != 2'd0);

  // Pop selection: B has priority unless A has lost STARVE_LIMIT times in a row
  always_comb begin
    w_pop_a     = 1'b0;
    w_pop_b     = 1'b0;
    w_pop_entry = '0;
    if (w_a_nempty && (!w_b_nempty || (r_skip_cnt == c_limit))) begin
      w_pop_a     = 1'b1;
      w_pop_entry = r_a_mem[r_a_rp];
    end else if (w_b_nempty) begin
      w_pop_b     = 1'b1;
      w_pop_entry = r_b_mem[r_b_rp];
    end
  end

  // Writes to register 0 still drain their slot but never reach the port
  assign w_do_write = (w_pop_a | w_pop_b) && (w_pop_entry[c_entry_w-1:32] != 5'd0);

  // FIFO A data storage (no reset needed; occupancy is tracked by the count)
  always_ff @(posedge clk) begin
    if (w_a_push && !reset) begin
      r_a_mem[r_a_wp] <= {a_addr, a_data};
    end
  end

  // FIFO A pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_wp  <= 1'b0;
      r_a_rp  <= 1'b0;
      r_a_cnt <= 2'd0;
    end else begin
      if (w_a_push) r_a_wp <= ~r_a_wp;
      if (w_pop_a)  r_a_rp <= ~r_a_rp;
      case ({w_a_push, w_pop_a})
        2'b10:   r_a_cnt <= r_a_cnt + 2'd1;
        2'b01:   r_a_cnt <= r_a_cnt - 2'd1;
        default: r_a_cnt <= r_a_cnt;
      endcase
    end
  end

  // FIFO B data storage
  always_ff @(posedge clk) begin
    if (w_b_push && !reset) begin
      r_b_mem[r_b_wp] <= {b_addr, b_data};
    end
  end

  // FIFO B pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk) begin
    if (reset) begin
      r_b_wp  <= 1'b0;
      r_b_rp  <= 1'b0;
      r_b_cnt <= 2'd0;
    end else begin
      if (w_b_push) r_b_wp <= ~r_b_wp;
      if (w_pop_b)  r_b_rp <= ~r_b_rp;
      case ({w_b_push, w_pop_b})
        2'b10:   r_b_cnt <= r_b_cnt + 2'd1;
        2'b01:   r_b_cnt <= r_b_cnt - 2'd1;
        default: r_b_cnt <= r_b_cnt;
      endcase
    end
  end

  // Starvation counter: counts consecutive B wins while A is waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      r_skip_cnt <= 2'd0;
    end else if (!w_a_nempty || w_pop_a) begin
      r_skip_cnt <= 2'd0;
    end else if (w_pop_b && (r_skip_cnt < c_limit)) begin
      r_skip_cnt <= r_skip_cnt + 2'd1;
    end
  end

  // Registered write port; address/data hold while no write is issued
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_w_out      <= 1'b0;
      reg_addr_w_out <= 5'd0;
      reg_data_w_out <= 32'd0;
    end else if (w_do_write) begin
      reg_w_out      <= 1'b1;
      reg_addr_w_out <= w_pop_entry[c_entry_w-1:32];
      reg_data_w_out <= w_pop_entry[31:0];
    end else begin
      reg_w_out      <= 1'b0;
    end
  end

  assign idle = (r_a_cnt == 2'd0) && (r_b_cnt == 2'd0) && !reg_w_out;

endmodule
`default_nettype wire
